// File: rtl/counter_pkg.sv
// Shared types and helpers for the temporal (negedge) counter datapath.
// k_of gives the number of right shifts of max needed to reach a value <= v.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    localparam int VALUE_W = 8;

    function automatic int k_of(int max, int v);
        int s;
        int k;
        s = max;
        k = 0;
        while (s > v) begin
            s = s >> 1;
            k = k + 1;
        end
        return k;
    endfunction

endpackage

// File: rtl/encoder_negedge_t.sv
// Binary -> temporal negedge encoder: the line stays high for k cycles of an
// epoch, where MAX_VALUE >> k is the largest shifted magnitude <= the value.
module encoder_negedge_t
    import counter_pkg::*;
#(
    parameter int MAX_VALUE = 8,
    parameter int WINDOW    = $clog2(MAX_VALUE) + 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               value_valid,
    input  logic [VALUE_W-1:0] value,
    output logic               value_ready,
    output logic               epoch_start,
    output logic               outgoing_line,
    output logic               epoch_done
);

    localparam int CNT_W = ($clog2(WINDOW) > 0) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [VALUE_W-1:0] MAX_V    = VALUE_W'(MAX_VALUE);

    enc_state_t         state_q, state_d;
    logic [VALUE_W-1:0] shadow_q, shadow_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               line_q, line_d;
    logic               start_q, start_d;
    logic               done_q, done_d;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        start_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    value_d  = value;
                    shadow_d = MAX_V;
                    cnt_d    = '0;
                    state_d  = RUN;
                    start_d  = 1'b1;
                    line_d   = (MAX_V > value);
                end
            end
            RUN: begin
                // Shadow only advances while the line is high, so once it falls it stays low.
                if (line_q) begin
                    shadow_d = shadow_q >> 1;
                    line_d   = ((shadow_q >> 1) > value_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    line_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= MAX_V;
            value_q  <= '0;
            cnt_q    <= '0;
            line_q   <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign value_ready   = (state_q == IDLE);
    assign epoch_start   = start_q;
    assign outgoing_line = line_q;
    assign epoch_done    = done_q;

    if (WINDOW < k_of(MAX_VALUE, 0) + 1) begin : g_window_chk
        $error("encoder_negedge_t: WINDOW shorter than max k + 1");
    end

    a_line_monotone: assert property (@(posedge clock) disable iff (reset)
        (state_q == RUN && $past(state_q) == RUN && !$past(line_q)) |-> !line_q);

    a_ready_idle: assert property (@(posedge clock) disable iff (reset)
        value_ready |-> (state_q == IDLE));

endmodule
